// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-ROM arbiter: window constants, FSM state,
// port index type and the address legality check.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'h0040_0000;
  localparam int unsigned IMEM_DEPTH = 1024;
  localparam logic [31:0] IMEM_LAST  = 32'h0040_0FFF;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  typedef logic port_idx_t;

  // Inclusive window bounds, compared unsigned in 32 bits so nothing wraps into the window.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
    return (addr >= base) && (addr <= last) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is one-hot and only asserted when advance is high;
// last_grant moves only on an actual grant.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  port_idx_t  last_q;
  logic [1:0] pick;

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_q ? 2'b01 : 2'b10;
    end
    grant = advance ? pick : 2'b00;
  end

  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= pick[1];
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction ROM read port between fetch (port 0) and data-side reads (port 1),
// with range/alignment checking and a single registered response slot.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
);

  localparam logic [31:0] LastAddr = BASE_ADDR + 32'(DEPTH_WORDS * 4) - 32'd1;

  state_e      state_q;
  port_idx_t   owner_q;
  logic [31:0] data_q;
  logic        err_q;

  logic [1:0]  req_v;
  logic [1:0]  grant;
  logic        owner_ready;
  logic        free;
  logic        advance;
  port_idx_t   gnt_port;
  logic [31:0] gnt_addr;
  logic        legal;

  always_comb begin
    req_v       = {req1_valid, req0_valid};
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    // The held response is consumed this edge, so the slot can be refilled at once.
    free        = (state_q == IDLE) || owner_ready;
    advance     = free && (|req_v) && !rst;
    gnt_port    = grant[1];
    gnt_addr    = gnt_port ? req1_addr : req0_addr;
    legal       = addr_legal(gnt_addr, BASE_ADDR, LastAddr);
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_v),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (|grant) begin
      state_q <= RESP;
      owner_q <= gnt_port;
      data_q  <= legal ? mem_data : 32'h0;
      err_q   <= !legal;
    end else if ((state_q == RESP) && owner_ready) begin
      state_q <= IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end
  end

  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    // Illegal addresses never reach the ROM.
    mem_addr   = ((|grant) && legal) ? gnt_addr : 32'h0;
    rsp0_valid = (state_q == RESP) && (owner_q == 1'b0);
    rsp1_valid = (state_q == RESP) && (owner_q == 1'b1);
    rsp0_data  = rsp0_valid ? data_q : 32'h0;
    rsp0_err   = rsp0_valid && err_q;
    rsp1_data  = rsp1_valid ? data_q : 32'h0;
    rsp1_err   = rsp1_valid && err_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, reset corner cases and
// randomized traffic against a transaction-level reference model.
module tb_imem_arbiter;

  localparam logic [31:0] Base = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_addr, req1_addr;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, mem_addr, mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: at most one pending response, plus who won the last grant.
  bit          m_pend_v;
  int          m_pend_port;
  logic [31:0] m_pend_data;
  bit          m_pend_err;
  int          m_last;

  imem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int unsigned idx);
    logic [31:0] w;
    w = 32'(idx) * 32'h9E37_79B1;
    return (idx == 0) ? 32'h0050_0093 : (w ^ 32'h5A5A_0000);
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return (a >= Base) && ((a - Base) < 32'd4096) && ((a % 4) == 0);
  endfunction

  // ROM returns garbage outside the window so a leaked illegal read shows up in the data.
  always_comb begin
    if (mem_addr >= Base && mem_addr - Base < 32'd4096) begin
      mem_data = rom_word(int'((mem_addr - Base) >> 2));
    end else begin
      mem_data = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input bit v0, input logic [31:0] a0, input bit v1,
                       input logic [31:0] a1, input bit r0, input bit r1);
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic model_reset();
    m_pend_v = 0; m_pend_port = 0; m_pend_data = '0; m_pend_err = 0; m_last = 1;
  endtask

  function automatic int model_grant();
    bit free;
    free = !m_pend_v || (m_pend_port == 0 ? rsp0_ready : rsp1_ready);
    if (!free) return -1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_check(input string tag);
    int g;
    logic [31:0] ga;
    g  = model_grant();
    ga = (g == 1) ? req1_addr : req0_addr;
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(g == 0));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(g == 1));
    check({tag, " mem_addr"}, mem_addr, (g >= 0 && in_window(ga)) ? ga : 32'h0);
    check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(m_pend_v && m_pend_port == 0));
    check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(m_pend_v && m_pend_port == 1));
    check({tag, " rsp0_data"}, rsp0_data,
          (m_pend_v && m_pend_port == 0) ? m_pend_data : 32'h0);
    check({tag, " rsp1_data"}, rsp1_data,
          (m_pend_v && m_pend_port == 1) ? m_pend_data : 32'h0);
    check({tag, " rsp0_err"}, 32'(rsp0_err), 32'(m_pend_v && m_pend_port == 0 && m_pend_err));
    check({tag, " rsp1_err"}, 32'(rsp1_err), 32'(m_pend_v && m_pend_port == 1 && m_pend_err));
  endtask

  // Advance one clock and apply the accepted transaction to the model.
  task automatic tick(output int g);
    logic [31:0] ga;
    g  = model_grant();
    ga = (g == 1) ? req1_addr : req0_addr;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_pend_v    = 1;
      m_pend_port = g;
      m_pend_err  = !in_window(ga);
      m_pend_data = in_window(ga) ? rom_word(int'((ga - Base) >> 2)) : 32'h0;
      m_last      = g;
    end else if (m_pend_v && (m_pend_port == 0 ? rsp0_ready : rsp1_ready)) begin
      m_pend_v = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req0_ready"}, 32'(req0_ready), 32'h0);
    check({tag, " req1_ready"}, 32'(req1_ready), 32'h0);
    check({tag, " mem_addr"}, mem_addr, 32'h0);
    check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'h0);
    check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'h0);
    check({tag, " rsp0_data"}, rsp0_data, 32'h0);
    check({tag, " rsp1_data"}, rsp1_data, 32'h0);
    check({tag, " rsp0_err"}, 32'(rsp0_err), 32'h0);
    check({tag, " rsp1_err"}, 32'(rsp1_err), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 7:    return Base + 32'($urandom_range(0, 1023)) * 4;
      1:       return Base;
      2:       return 32'h0040_0FFC;
      3:       return 32'h0040_1000;
      4:       return 32'h003F_FFFC;
      5:       return Base + 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    bit          v0;
    logic [31:0] a0;
    bit          v1;
    logic [31:0] a1;
    bit          r0;
    bit          r1;
    bit          rdy0;
    bit          rdy1;
    logic [31:0] mem;
    bit          rv0;
    logic [31:0] d0;
    bit          e0;
    bit          rv1;
    logic [31:0] d1;
    bit          e1;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int g;
    logic [31:0] w1, w2, w4, wl;
    bit acc0, acc1;

    w1 = rom_word(1); w2 = rom_word(2); w4 = rom_word(4); wl = rom_word(1023);
    //          v0 a0            v1 a1            r0 r1 rdy0 rdy1 mem  rv0 d0 e0 rv1 d1 e1
    tbl[0]  = '{1, 32'h0040_0004, 1, 32'h0040_0008, 1, 1, 1, 0, 32'h0040_0004,
                0, 32'h0, 0, 0, 32'h0, 0};
    tbl[1]  = '{1, 32'h0040_0004, 1, 32'h0040_0008, 1, 1, 0, 1, 32'h0040_0008,
                1, w1, 0, 0, 32'h0, 0};
    tbl[2]  = '{1, 32'h0040_0004, 1, 32'h0040_0008, 1, 1, 1, 0, 32'h0040_0004,
                0, 32'h0, 0, 1, w2, 0};
    tbl[3]  = '{1, 32'h0040_0004, 1, 32'h0040_0008, 1, 1, 0, 1, 32'h0040_0008,
                1, w1, 0, 0, 32'h0, 0};
    tbl[4]  = '{0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, w2, 0};
    tbl[5]  = '{0, 32'h0, 1, 32'h0040_1000, 1, 1, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0};
    tbl[6]  = '{0, 32'h0, 1, 32'h003F_FFFC, 1, 1, 0, 1, 32'h0, 0, 32'h0, 0, 1, 32'h0, 1};
    tbl[7]  = '{0, 32'h0, 1, 32'h0040_0002, 1, 1, 0, 1, 32'h0, 0, 32'h0, 0, 1, 32'h0, 1};
    tbl[8]  = '{1, 32'h0040_0FFC, 0, 32'h0, 1, 1, 1, 0, 32'h0040_0FFC,
                0, 32'h0, 0, 1, 32'h0, 1};
    tbl[9]  = '{0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, wl, 0, 0, 32'h0, 0};
    tbl[10] = '{0, 32'h0, 1, 32'h0040_0010, 0, 1, 0, 0, 32'h0, 1, wl, 0, 0, 32'h0, 0};
    tbl[11] = tbl[10];
    tbl[12] = tbl[10];
    tbl[13] = tbl[10];
    tbl[14] = '{0, 32'h0, 1, 32'h0040_0010, 1, 1, 0, 1, 32'h0040_0010,
                1, wl, 0, 0, 32'h0, 0};
    tbl[15] = '{0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, w4, 0};
    tbl[16] = '{0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0};

    // Reset with requests already pending: every output must stay low.
    rst = 1'b1;
    apply(1, Base, 1, Base + 4, 1, 1);
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // First access of the test plan: port 0 reads word 0.
    apply(1, Base, 0, 32'h0, 1, 1);
    #3;
    check("first req0_ready", 32'(req0_ready), 32'h1);
    check("first mem_addr", mem_addr, Base);
    tick(g);
    apply(0, 32'h0, 0, 32'h0, 1, 1);
    #3;
    check("first rsp0_valid", 32'(rsp0_valid), 32'h1);
    check("first rsp0_data", rsp0_data, 32'h0050_0093);
    check("first rsp0_err", 32'(rsp0_err), 32'h0);
    tick(g);

    // Re-reset so the table starts from the post-reset arbitration state.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].r0, tbl[i].r1);
      #3;
      check({t, " req0_ready"}, 32'(req0_ready), 32'(tbl[i].rdy0));
      check({t, " req1_ready"}, 32'(req1_ready), 32'(tbl[i].rdy1));
      check({t, " mem_addr"}, mem_addr, tbl[i].mem);
      check({t, " rsp0_valid"}, 32'(rsp0_valid), 32'(tbl[i].rv0));
      check({t, " rsp0_data"}, rsp0_data, tbl[i].d0);
      check({t, " rsp0_err"}, 32'(rsp0_err), 32'(tbl[i].e0));
      check({t, " rsp1_valid"}, 32'(rsp1_valid), 32'(tbl[i].rv1));
      check({t, " rsp1_data"}, rsp1_data, tbl[i].d1);
      check({t, " rsp1_err"}, 32'(rsp1_err), 32'(tbl[i].e1));
      tick(g);
    end

    // Asynchronous reset in the middle of a held response.
    apply(1, Base + 8, 0, 32'h0, 1, 1);
    #3;
    tick(g);
    apply(1, Base + 12, 1, Base + 16, 0, 0);
    #1;
    model_check("midrst pre");
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    apply(1, Base + 12, 1, Base + 16, 1, 1);
    #3;
    check("midrst first grant", 32'({req1_ready, req0_ready}), 32'h1);
    model_check("midrst post");
    tick(g);

    // Randomized traffic; an address is held until its request is accepted.
    acc0 = 1; acc1 = 1;
    for (int c = 0; c < 3000; c++) begin
      logic        v0, v1;
      logic [31:0] a0, a1;
      v0 = req0_valid; a0 = req0_addr; v1 = req1_valid; a1 = req1_addr;
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 9) < 7);
        a0 = rand_addr();
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 9) < 7);
        a1 = rand_addr();
      end
      apply(v0, a0, v1, a1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      #3;
      model_check($sformatf("rand%0d", c));
      tick(g);
      acc0 = (g == 0);
      acc1 = (g == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single combinational read port of the instruction ROM (text window 0x0040_0000–0x0040_0FFF, 1K words) between two requesters: port 0 for instruction fetch and port 1 for data-side reads of the text segment (loader/debug/constant loads). Requests use a valid/ready handshake and are granted round-robin. The granted address is driven to the ROM, and the returned word is registered into a per-port response with one-cycle latency. Range and alignment checking is done here, so the ROM never sees an illegal access.

## Interface
- BASE_ADDR, 32'h0040_0000, first byte address of the ROM window
- DEPTH_WORDS, 1024, ROM depth in 32-bit words; window size is 4*DEPTH_WORDS bytes
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  port N (N=0,1) request valid
- reqN_ready  out  1  port N request accepted this cycle when valid&&ready
- reqN_addr  in  32  port N byte address; stable while valid && !ready
- rspN_valid  out  1  port N response valid
- rspN_ready  in  1  port N consumer accepts response
- rspN_data  out  32  port N read word; 0 when error
- rspN_err  out  1  port N address out of window or addr[1:0]!=0
- mem_addr  out  32  address to ROM; granted address in the grant cycle, else 0
- mem_data  in  32  ROM combinational read data

## Operation
- State machine: IDLE (no response held), RESP (one response held for port `owner`).
- Port free condition: `free = (state==IDLE) || (rsp[owner]_valid && rsp[owner]_ready)`, which gives back-to-back throughput of 1 access/cycle.
- Grant:
  - When `free` and at least one reqN_valid, grant exactly one port.
  - Round-robin: if both ports are valid, grant the port not granted last; if only one is valid, grant it.
  - `last_grant` updates only on an actual grant.
- reqN_ready is 1 only for the granted port in the grant cycle. It must not depend combinationally on reqN_valid of the same port beyond the arbitration itself.
- On grant at edge:
  - owner ← granted port; state ← RESP.
  - rsp_data ← mem_data if legal, else 0.
  - rsp_err ← !legal.
- Legal address: BASE_ADDR ≤ addr ≤ BASE_ADDR+4*DEPTH_WORDS-1 and addr[1:0]==0. Compare in 32 bits unsigned; no wrap into the window.
- Illegal addresses still complete the handshake, so the requester is never hung.
- In RESP without rsp handshake: hold data/err/owner, and no new grant.
- In RESP with rsp handshake and no grant: go to IDLE.
- rspN_valid = (state==RESP && owner==N). The non-owner's rsp outputs are 0.

## Timing
- Latency: request accepted at edge k gives rspN_valid high from cycle k+1 until the rsp handshake edge.
- Sustained throughput: 1 grant/cycle when rspN_ready is held high.
- Alternation when both ports are continuously valid: 0,1,0,1…
- Simultaneous rsp handshake on owner A and new grant to B: at that edge owner←B, and rspA_valid drops in the same cycle rspB_valid rises.
- Reset value of all outputs is 0: reqN_ready=0, rspN_valid=0, rspN_data=0, rspN_err=0, mem_addr=0.
- Internal reset values: state=IDLE, owner=0, last_grant=1, so port 0 wins the first contention.
- Reset mid-operation: a held response is discarded, no replay; the requester must reissue.
- Backpressure: a stalled consumer on port A blocks port B as well, since there is a single response slot. This is intended; fetch stalls are handled upstream.

## Structure
- Shared package `imem_pkg`:
  - IMEM_BASE = 32'h0040_0000, IMEM_DEPTH = 1024, IMEM_LAST = 32'h0040_0FFF.
  - State enum {IDLE, RESP}.
  - Port index type (1 bit).
- Sub-module `rr_arb2`:
  - Inputs: clk, rst, req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Owns last_grant; advance = free && |req.
- Top level holds the legality check, response registers and state.

## Test plan
- Reset, then req0 valid addr 0x0040_0000 with ROM word 0x00500093 → req0_ready in same cycle; next cycle rsp0_valid=1, data=0x00500093, err=0.
- req0 and req1 both valid continuously, addrs 0x0040_0004 / 0x0040_0008, rsp ready=1 → grants alternate 0,1,0,1, one response per cycle, port 0 first after reset.
- req1 addr 0x0040_1000 (one past end), then 0x003F_FFFC, then 0x0040_0002 → each rsp1_valid with err=1, data=0; mem_addr never outside window.
- rsp0_ready=0 for 5 cycles while req1 valid → rsp0 data held stable, req1_ready=0 throughout; rsp0_ready=1 → req1 granted in that same cycle, rsp1_valid next cycle.
- Last legal word 0x0040_0FFC → err=0, data=ROM[1023].
- rst asserted asynchronously mid-cycle while rsp0_valid=1 → all outputs 0 immediately; after release, first contention grants port 0.
